// File: rtl/alu_mdu.sv
// Multi-cycle ALU with iterative unsigned multiply (shift-add) and divide (restoring).
// Single-cycle ops complete in one clock; mul/mulhu/divu/remu take WIDTH+1 clocks.
module alu_mdu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   srca,
  input  logic [WIDTH-1:0]   srcb,
  input  logic [3:0]         alucontrol,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   aluout,
  output logic               zero,
  output logic               illegal
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SLL   = 4'b0001;
  localparam logic [3:0] OP_SLT   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_SUB   = 4'b1000;
  localparam logic [3:0] OP_MUL   = 4'b1001;
  localparam logic [3:0] OP_MULHU = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_REMU  = 4'b1100;
  localparam logic [3:0] OP_SRA   = 4'b1101;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_nxt;
  logic [3:0]           op_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0]   cnt;

  logic                 accept, is_iter, is_div, div_zero, go_calc, op_q_div;
  logic [WIDTH-1:0]     alu_res, iter_res;
  logic                 alu_ill;
  logic [WIDTH:0]       mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0]   mul_nxt, div_nxt, step_nxt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;

  assign is_div   = (alucontrol == OP_DIVU) || (alucontrol == OP_REMU);
  assign is_iter  = is_div || (alucontrol == OP_MUL) || (alucontrol == OP_MULHU);
  assign div_zero = is_div && (srcb == '0);
  assign go_calc  = is_iter && !div_zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = go_calc ? CALC : DONE;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle results; divide-by-zero is resolved here so it never enters CALC.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (alucontrol)
      OP_ADD:  alu_res = srca + srcb;
      OP_SUB:  alu_res = srca - srcb;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(srca) < $signed(srcb)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, srca < srcb};
      OP_SLL:  alu_res = srca << shamt;
      OP_SRL:  alu_res = srca >> shamt;
      OP_SRA:  alu_res = $signed(srca) >>> shamt;
      OP_XOR:  alu_res = srca ^ srcb;
      OP_OR:   alu_res = srca | srcb;
      OP_AND:  alu_res = srca & srcb;
      OP_DIVU: alu_res = '1;
      OP_REMU: alu_res = srca;
      OP_MUL, OP_MULHU: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // acc holds {hi, lo} for multiply and {remainder, quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : '0);
    mul_nxt   = {mul_sum, acc[WIDTH-1:1]};
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_trial = div_shift - {1'b0, b_q};
    div_nxt   = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    op_q_div  = (op_q == OP_DIVU) || (op_q == OP_REMU);
    step_nxt  = op_q_div ? div_nxt : mul_nxt;
    iter_res  = ((op_q == OP_MULHU) || (op_q == OP_REMU)) ? step_nxt[2*WIDTH-1:WIDTH]
                                                          : step_nxt[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      b_q     <= '0;
      acc     <= '0;
      cnt     <= '0;
      aluout  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q <= alucontrol;
          b_q  <= srcb;
          cnt  <= SHAMT_W'(WIDTH-1);
          if (go_calc) begin
            acc <= {{WIDTH{1'b0}}, srca};
          end else begin
            aluout  <= alu_res;
            zero    <= (alu_res == '0);
            illegal <= alu_ill;
          end
        end
        CALC: begin
          acc <= step_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            aluout  <= iter_res;
            zero    <= (iter_res == '0);
            illegal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: a 32-bit and a 16-bit instance share clock and reset.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        reset;

  logic        iv32, ir32, ov32, or32, z32, il32;
  logic [31:0] a32, b32, y32;
  logic [3:0]  op32;
  logic [4:0]  sh32;

  logic        iv16, ir16, ov16, or16, z16, il16;
  logic [15:0] a16, b16, y16;
  logic [3:0]  op16;
  logic [3:0]  sh16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(32), .SHAMT_W(5)) dut32 (
    .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32),
    .srca(a32), .srcb(b32), .alucontrol(op32), .shamt(sh32),
    .out_valid(ov32), .out_ready(or32), .aluout(y32), .zero(z32), .illegal(il32)
  );

  alu_mdu #(.WIDTH(16), .SHAMT_W(4)) dut16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16),
    .srca(a16), .srcb(b16), .alucontrol(op16), .shamt(sh16),
    .out_valid(ov16), .out_ready(or16), .aluout(y16), .zero(z16), .illegal(il16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op on the selected instance, wait for out_valid (bounded), then handshake.
  task automatic run_op(input bit w16, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh,
                        output logic [31:0] res, output logic z, output logic ill,
                        output int lat);
    if (w16) begin
      op16 = op; a16 = a[15:0]; b16 = b[15:0]; sh16 = sh[3:0]; iv16 = 1'b1;
    end else begin
      op32 = op; a32 = a; b32 = b; sh32 = sh; iv32 = 1'b1;
    end
    @(posedge clk); #1;
    iv16 = 1'b0; iv32 = 1'b0;
    lat = 1;
    while (!(w16 ? ov16 : ov32) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = w16 ? {16'h0, y16} : y32;
    z   = w16 ? z16 : z32;
    ill = w16 ? il16 : il32;
    if (w16) or16 = 1'b1; else or32 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0; or32 = 1'b0;
  endtask

  task automatic op_chk(input string tag, input bit w16, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                        input logic [31:0] exp_res, input logic exp_z, input logic exp_ill,
                        input int exp_lat);
    logic [31:0] res;
    logic        z, ill;
    int          lat;
    run_op(w16, op, a, b, sh, res, z, ill, lat);
    chk({tag, "_res"}, 64'(res), 64'(exp_res));
    chk({tag, "_zero"}, 64'(z), 64'(exp_z));
    chk({tag, "_ill"}, 64'(ill), 64'(exp_ill));
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    iv32 = 0; or32 = 0; a32 = 0; b32 = 0; op32 = 0; sh32 = 0;
    iv16 = 0; or16 = 0; a16 = 0; b16 = 0; op16 = 0; sh16 = 0;
    #2;
    chk("rst_out_valid", 64'(ov32), 64'd0);
    chk("rst_aluout", 64'(y32), 64'd0);
    chk("rst_zero", 64'(z32), 64'd0);
    chk("rst_illegal", 64'(il32), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_in_ready", 64'(ir32), 64'd1);

    // Reset in the middle of a multiply
    a32 = 32'd7; b32 = 32'd9; op32 = 4'b1001; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("midcalc_busy", 64'(ir32), 64'd0);
    reset = 1'b1; #1;
    chk("midrst_out_valid", 64'(ov32), 64'd0);
    chk("midrst_aluout", 64'(y32), 64'd0);
    chk("midrst_in_ready", 64'(ir32), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("postrst_in_ready", 64'(ir32), 64'd1);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (ov32) seen = 1'b1; end
    chk("no_stale_output", 64'(seen), 64'd0);

    // Single-cycle ops
    op_chk("add_wrap", 0, 4'b0000, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1, 0, 1);
    op_chk("sub",      0, 4'b1000, 32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE, 0, 0, 1);
    op_chk("slt",      0, 4'b0010, 32'hFFFF_FFFE, 32'd1, 5'd0, 32'd1, 0, 0, 1);
    op_chk("sltu",     0, 4'b0011, 32'hFFFF_FFFE, 32'd1, 5'd0, 32'd0, 1, 0, 1);
    op_chk("sra",      0, 4'b1101, 32'h8000_0000, 32'h1234, 5'd4, 32'hF800_0000, 0, 0, 1);
    op_chk("srl",      0, 4'b0101, 32'h8000_0000, 32'h0, 5'd31, 32'h1, 0, 0, 1);
    op_chk("sll",      0, 4'b0001, 32'h1, 32'hFF, 5'd31, 32'h8000_0000, 0, 0, 1);
    op_chk("xor",      0, 4'b0100, 32'hF0F0, 32'hFF00, 5'd0, 32'h0FF0, 0, 0, 1);
    op_chk("or",       0, 4'b0110, 32'hF0F0, 32'hFF00, 5'd0, 32'hFFF0, 0, 0, 1);
    op_chk("and",      0, 4'b0111, 32'hF0F0, 32'hFF00, 5'd0, 32'hF000, 0, 0, 1);

    // Iterative multiply
    op_chk("mul_7x9",  0, 4'b1001, 32'd7, 32'd9, 5'd0, 32'd63, 0, 0, 33);
    op_chk("mul_big",  0, 4'b1001, 32'h10000, 32'h10000, 5'd0, 32'h0, 1, 0, 33);
    op_chk("mulhu_big",0, 4'b1010, 32'h10000, 32'h10000, 5'd0, 32'h1, 0, 0, 33);
    op_chk("mul_ones", 0, 4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h1, 0, 0, 33);
    op_chk("mulhu_ones",0,4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFE, 0, 0, 33);

    // Iterative divide and divide-by-zero shortcut
    op_chk("divu",     0, 4'b1011, 32'd100, 32'd7, 5'd0, 32'd14, 0, 0, 33);
    op_chk("remu",     0, 4'b1100, 32'd100, 32'd7, 5'd0, 32'd2, 0, 0, 33);
    op_chk("divu_max", 0, 4'b1011, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'hFFFF_FFFF, 0, 0, 33);
    op_chk("remu_max", 0, 4'b1100, 32'hFFFF_FFFF, 32'd10, 5'd0, 32'd5, 0, 0, 33);
    op_chk("divu_by0", 0, 4'b1011, 32'd100, 32'd0, 5'd0, 32'hFFFF_FFFF, 0, 0, 1);
    op_chk("remu_by0", 0, 4'b1100, 32'h1234, 32'd0, 5'd0, 32'h1234, 0, 0, 1);

    // Illegal ops, then a legal op clears the flag
    op_chk("ill_1110", 0, 4'b1110, 32'h55, 32'h66, 5'd0, 32'h0, 1, 1, 1);
    op_chk("ill_1111", 0, 4'b1111, 32'h55, 32'h66, 5'd0, 32'h0, 1, 1, 1);
    op_chk("after_ill",0, 4'b0000, 32'd2, 32'd3, 5'd0, 32'd5, 0, 0, 1);

    // Backpressure: result held, new op waits for the DONE handshake
    a32 = 32'd3; b32 = 32'd4; op32 = 4'b0000; iv32 = 1'b1;
    @(posedge clk); #1;
    chk("bp_first_valid", 64'(ov32), 64'd1);
    chk("bp_first_res", 64'(y32), 64'd7);
    a32 = 32'd10; b32 = 32'd1; op32 = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_res", 64'(y32), 64'd7);
      chk("bp_hold_ready", 64'(ir32), 64'd0);
      chk("bp_hold_valid", 64'(ov32), 64'd1);
    end
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;
    chk("bp_release_valid", 64'(ov32), 64'd0);
    chk("bp_release_ready", 64'(ir32), 64'd1);
    @(posedge clk); #1;
    iv32 = 1'b0;
    chk("bp_second_valid", 64'(ov32), 64'd1);
    chk("bp_second_res", 64'(y32), 64'd9);
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;

    // 16-bit instance
    op_chk("w16_add_wrap", 1, 4'b0000, 32'hFFFF, 32'h1, 5'd0, 32'h0, 1, 0, 1);
    op_chk("w16_mul",      1, 4'b1001, 32'd300, 32'd200, 5'd0, 32'hEA60, 0, 0, 17);
    op_chk("w16_mul_big",  1, 4'b1001, 32'h100, 32'h100, 5'd0, 32'h0, 1, 0, 17);
    op_chk("w16_mulhu",    1, 4'b1010, 32'h100, 32'h100, 5'd0, 32'h1, 0, 0, 17);
    op_chk("w16_divu",     1, 4'b1011, 32'd1000, 32'd7, 5'd0, 32'd142, 0, 0, 17);
    op_chk("w16_remu",     1, 4'b1100, 32'd1000, 32'd7, 5'd0, 32'd6, 0, 0, 17);
    op_chk("w16_divu_by0", 1, 4'b1011, 32'd1000, 32'd0, 5'd0, 32'hFFFF, 0, 0, 1);
    op_chk("w16_sra",      1, 4'b1101, 32'h8000, 32'h0, 5'd4, 32'hF800, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
